byte_mem_arb: RTL and testbench

BYTE_MEM_ARB -- requirements
Module: byte_mem_arb

---
 rtl/bilib_mem_pkg.sv | 16 +
 rtl/byte_mem_arb_rr_arbiter.sv | 38 +++
 rtl/byte_mem_arb.sv | 125 ++++++++++++
 tb/tb_byte_mem_arb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bilib_mem_pkg.sv
// Shared definitions for the byte-memory library: requester-count bound,
// port-index type and round-robin pointer helper.
package bilib_mem_pkg;

  localparam int unsigned MAX_PORTS  = 8;
  localparam int unsigned PORT_IDX_W = 3;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // Next round-robin start position after idx, wrapping at ports.
  function automatic port_idx_t wrap_inc(input port_idx_t idx, input int unsigned ports);
    if (32'(idx) + 32'd1 >= ports) return '0;
    return port_idx_t'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/byte_mem_arb_rr_arbiter.sv
// Round-robin selector: first requester at or after ptr wins; outputs a
// one-hot grant plus the winner's index.
module RrArbiter
  import bilib_mem_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  port_idx_t    ptr,
  output logic [N-1:0] grant,
  output port_idx_t    idx,
  output logic         found
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    sum;

  // Rotate requests so that bit 0 corresponds to the pointer position.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = 32'(ptr) + i;
        if (sum >= N) sum = sum - N;
        idx   = port_idx_t'(sum);
      end
    end
    grant = found ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
  end

endmodule

// File: rtl/byte_mem_arb.sv
// Multi-requester arbiter in front of a single-port byte-masked memory:
// one registered command slot, round-robin grants, one-cycle response.
module byte_mem_arb
  import bilib_mem_pkg::*;
#(
  parameter int unsigned PORTS     = 2,
  parameter int unsigned DATA_BYTE = 4,
  parameter int unsigned ADDR_SIZE = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [PORTS-1:0]              reqValid_i,
  output logic [PORTS-1:0]              reqReady_o,
  input  logic [PORTS-1:0]              reqIsWrite_i,
  input  logic [PORTS*DATA_BYTE-1:0]    reqMask_i,
  input  logic [PORTS*ADDR_SIZE-1:0]    reqAddr_i,
  input  logic [PORTS*DATA_BYTE*8-1:0]  reqData_i,
  output logic [PORTS-1:0]              rspValid_o,
  output logic [DATA_BYTE*8-1:0]        rspData_o,
  output logic                          memEnable_o,
  output logic                          memIsWrite_o,
  output logic [DATA_BYTE-1:0]          memMask_o,
  output logic [ADDR_SIZE-1:0]          memAddr_o,
  output logic [DATA_BYTE*8-1:0]        memData_o,
  input  logic [DATA_BYTE*8-1:0]        memReadData_i,
  input  logic                          memHold_i
);

  localparam int unsigned DW = DATA_BYTE * 8;

  if (PORTS < 2 || PORTS > MAX_PORTS) begin : g_bad_ports
    $error("byte_mem_arb: PORTS out of range");
  end

  logic                 cmd_valid;
  port_idx_t            owner;
  logic                 cmd_write;
  logic [DATA_BYTE-1:0] cmd_mask;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic [DW-1:0]        cmd_data;
  port_idx_t            rr_ptr;
  logic                 rsp_pend;
  port_idx_t            rsp_owner;

  logic                 issue;
  logic                 slot_free;
  logic [PORTS-1:0]     arb_req;
  logic [PORTS-1:0]     grant;
  port_idx_t            win;
  logic                 win_valid;

  logic                 sel_write;
  logic [DATA_BYTE-1:0] sel_mask;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [DW-1:0]        sel_data;

  assign issue     = cmd_valid & ~memHold_i;
  assign slot_free = ~cmd_valid | issue;
  assign arb_req   = slot_free ? reqValid_i : '0;

  RrArbiter #(.N(PORTS)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win),
    .found (win_valid)
  );

  // Reset gates ready: with the slot cleared the arbiter alone would grant.
  assign reqReady_o = rst_ni ? grant : '0;

  always_comb begin
    sel_write = 1'b0;
    sel_mask  = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (grant[p]) begin
        sel_write = reqIsWrite_i[p];
        sel_mask  = reqMask_i[p*DATA_BYTE +: DATA_BYTE];
        sel_addr  = reqAddr_i[p*ADDR_SIZE +: ADDR_SIZE];
        sel_data  = reqData_i[p*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_valid <= 1'b0;
      owner     <= '0;
      cmd_write <= 1'b0;
      cmd_mask  <= '0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      rr_ptr    <= '0;
      rsp_pend  <= 1'b0;
      rsp_owner <= '0;
    end else begin
      // A grant only happens when the slot is free, so it may overwrite an issuing command.
      if (win_valid) begin
        cmd_valid <= 1'b1;
        owner     <= win;
        cmd_write <= sel_write;
        cmd_mask  <= sel_mask;
        cmd_addr  <= sel_addr;
        cmd_data  <= sel_data;
        rr_ptr    <= wrap_inc(win, PORTS);
      end else if (issue) begin
        cmd_valid <= 1'b0;
      end
      rsp_pend <= issue;
      if (issue) rsp_owner <= owner;
    end
  end

  assign memEnable_o  = cmd_valid;
  assign memIsWrite_o = cmd_write;
  assign memMask_o    = cmd_mask;
  assign memAddr_o    = cmd_addr;
  assign memData_o    = cmd_data;

  assign rspValid_o = rsp_pend ? ({{(PORTS-1){1'b0}}, 1'b1} << rsp_owner) : '0;
  assign rspData_o  = rsp_pend ? memReadData_i : '0;

endmodule

// File: tb/tb_byte_mem_arb.sv
// Directed bench for byte_mem_arb with a registered byte-masked memory model
// (word i preloaded with 0x5A00_0000 | i).
module tb_byte_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [7:0]  req_mask;
  logic [63:0] req_addr, req_data;
  logic [31:0] rsp_data, mem_rdata, mem_data, mem_addr;
  logic        mem_en, mem_write, mem_hold;
  logic [3:0]  mem_mask;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  logic        mem_loaded = 1'b0;

  always #5 clk = ~clk;

  byte_mem_arb #(.PORTS(2), .DATA_BYTE(4), .ADDR_SIZE(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .reqValid_i(req_valid), .reqReady_o(req_ready), .reqIsWrite_i(req_write),
    .reqMask_i(req_mask), .reqAddr_i(req_addr), .reqData_i(req_data),
    .rspValid_o(rsp_valid), .rspData_o(rsp_data),
    .memEnable_o(mem_en), .memIsWrite_o(mem_write), .memMask_o(mem_mask),
    .memAddr_o(mem_addr), .memData_o(mem_data),
    .memReadData_i(mem_rdata), .memHold_i(mem_hold)
  );

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
      mem_rdata  <= '0;
      mem_loaded <= 1'b1;
    end else if (mem_en && !mem_hold) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem[mem_addr[7:2]][b*8 +: 8] <= mem_data[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[7:2]];
      end
    end
  end

  task automatic set_port(input int p, input logic v, input logic wr, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] d);
    req_valid[p]        = v;
    req_write[p]        = wr;
    req_mask[p*4 +: 4]  = m;
    req_addr[p*32 +: 32] = a;
    req_data[p*32 +: 32] = d;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; req_valid = '0; req_write = '0; req_mask = '0;
    req_addr = '0; req_data = '0; mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %h expected 0", mem_en); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (mem_write !== 1'b0 || mem_mask !== 4'h0) begin errors++; $display("FAIL rst_wr_mask: got %h/%h expected 0/0", mem_write, mem_mask); end
    checks++; if (mem_addr !== 32'h0 || mem_data !== 32'h0) begin errors++; $display("FAIL rst_addr_data: got %h/%h expected 0/0", mem_addr, mem_data); end
  endtask

  task automatic test_single_read();
    @(negedge clk); set_port(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0); #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sr_ready: got %b expected 01", req_ready); end
    @(negedge clk); set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10 || mem_write !== 1'b0) begin errors++; $display("FAIL sr_cmd: got en=%h addr=%h wr=%h expected 1/10/0", mem_en, mem_addr, mem_write); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL sr_early_rsp: got %b expected 00", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL sr_rsp_valid: got %b expected 01", rsp_valid); end
    checks++; if (rsp_data !== 32'h5A00_0004) begin errors++; $display("FAIL sr_rsp_data: got %h expected 5a000004", rsp_data); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL sr_idle: got %h expected 0", mem_en); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_addr;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_port(0, 1'b1, 1'b0, 4'h0, 32'h00, 32'h0);
      set_port(1, 1'b1, 1'b0, 4'h0, 32'h04, 32'h0);
      #1;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
      if (k >= 1) begin
        exp_addr = ((k - 1) % 2 == 0) ? 32'h00 : 32'h04;
        checks++; if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin errors++; $display("FAIL b2b_cmd[%0d]: got en=%h addr=%h expected 1/%h", k, mem_en, mem_addr, exp_addr); end
      end
      if (k >= 2) begin
        exp_rdy  = ((k - 2) % 2 == 0) ? 2'b01 : 2'b10;
        exp_addr = ((k - 2) % 2 == 0) ? 32'h5A00_0000 : 32'h5A00_0001;
        checks++; if (rsp_valid !== exp_rdy || rsp_data !== exp_addr) begin errors++; $display("FAIL b2b_rsp[%0d]: got %b/%h expected %b/%h", k, rsp_valid, rsp_data, exp_rdy, exp_addr); end
      end
    end
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold();
    @(negedge clk); set_port(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0); #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL hold_load: got %b expected 01", req_ready); end
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_port(1, 1'b1, 1'b0, 4'h0, 32'h04, 32'h0);
      mem_hold = 1'b1;
      #1;
      checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10 || mem_write !== 1'b0) begin errors++; $display("FAIL hold_stable[%0d]: got en=%h addr=%h expected 1/10", h, mem_en, mem_addr); end
      checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL hold_quiet[%0d]: got rdy=%b rsp=%b expected 00/00", h, req_ready, rsp_valid); end
    end
    @(negedge clk); mem_hold = 1'b0; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL hold_release_ready: got %b expected 10", req_ready); end
    @(negedge clk); set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h5A00_0004) begin errors++; $display("FAIL hold_rsp: got %b/%h expected 01/5a000004", rsp_valid, rsp_data); end
    checks++; if (mem_addr !== 32'h04) begin errors++; $display("FAIL hold_next_cmd: got %h expected 04", mem_addr); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h5A00_0001) begin errors++; $display("FAIL hold_rsp2: got %b/%h expected 10/5a000001", rsp_valid, rsp_data); end
  endtask

  task automatic test_write_mask();
    @(negedge clk); set_port(1, 1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD); #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_ready: got %b expected 10", req_ready); end
    @(negedge clk);
    set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_port(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    #1;
    checks++; if (mem_write !== 1'b1 || mem_mask !== 4'b0101 || mem_data !== 32'hAABB_CCDD || mem_addr !== 32'h20) begin errors++; $display("FAIL wr_cmd: got wr=%h m=%h d=%h a=%h expected 1/5/aabbccdd/20", mem_write, mem_mask, mem_data, mem_addr); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_rd_ready: got %b expected 01", req_ready); end
    @(negedge clk); set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL wr_ack: got %b expected 10", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h5ABB_00DD) begin errors++; $display("FAIL wr_readback: got %b/%h expected 01/5abb00dd", rsp_valid, rsp_data); end
  endtask

  task automatic test_withdraw();
    @(negedge clk); set_port(1, 1'b1, 1'b0, 4'h0, 32'h04, 32'h0); #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wd_ready: got %b expected 10", req_ready); end
    @(negedge clk);
    set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_port(0, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
    mem_hold = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL wd_blocked: got %b expected 00", req_ready); end
    @(negedge clk); set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); mem_hold = 1'b0;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b10 || mem_en !== 1'b0) begin errors++; $display("FAIL wd_rsp: got rsp=%b en=%h expected 10/0", rsp_valid, mem_en); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b00 || mem_en !== 1'b0) begin errors++; $display("FAIL wd_not_issued[%0d]: got rsp=%b en=%h expected 00/0", i, rsp_valid, mem_en); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); set_port(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'h0, 32'h04, 32'h0);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rm_ready: got %b expected 10", req_ready); end
    @(negedge clk);
    set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_port(0, 1'b1, 1'b0, 4'h0, 32'h08, 32'h0);
    mem_hold = 1'b1;
    #1;
    checks++; if (rsp_valid !== 2'b01 || mem_en !== 1'b1 || mem_addr !== 32'h04) begin errors++; $display("FAIL rm_pre: got rsp=%b en=%h addr=%h expected 01/1/04", rsp_valid, mem_en, mem_addr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL rm_async: got en=%h rsp=%b rdy=%b expected 0/00/00", mem_en, rsp_valid, req_ready); end
    checks++; if (mem_addr !== 32'h0 || mem_write !== 1'b0 || mem_mask !== 4'h0 || rsp_data !== 32'h0) begin errors++; $display("FAIL rm_fields: got a=%h w=%h m=%h d=%h expected 0", mem_addr, mem_write, mem_mask, rsp_data); end
    @(negedge clk);
    req_valid = '0; mem_hold = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b00 || mem_en !== 1'b0) begin errors++; $display("FAIL rm_stale[%0d]: got rsp=%b en=%h expected 00/0", i, rsp_valid, mem_en); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_hold();
    test_write_mask();
    test_withdraw();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
